// File: rtl/panda_risc_v_inst_buf.sv
// Instruction buffer between fetch and decode: circular FIFO with head pre-decode.
// Optional same-cycle bypass when empty: PANDA_RISC_V_INST_BUF_BYPASS_EN.
module panda_risc_v_inst_buf #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [31:0]                s_inst,
  input  logic [31:0]                s_pc,
  input  logic [63:0]                s_msg,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [31:0]                m_inst,
  output logic [31:0]                m_pc,
  output logic [8:0]                 m_type,
  output logic [20:0]                m_jump_ofs_imm,
  output logic                       m_rs1_vld,
  output logic                       m_rs2_vld,
  output logic                       m_rd_vld,
  output logic [11:0]                m_csr_addr,
  output logic [31:0]                m_jump_target,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     m_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [44:0] msg_mem  [DEPTH];

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          full;
  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;
  logic [31:0]   h_inst;
  logic [31:0]   h_pc;
  logic [44:0]   h_msg;
  logic          unused_msg;

  assign unused_msg = ^s_msg[63:45];

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

`ifdef PANDA_RISC_V_INST_BUF_BYPASS_EN
  assign byp = empty & s_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign s_ready = ~full;
  assign m_valid = ~empty | byp;
  // A bypassed word consumed this cycle never touches storage.
  assign push    = s_valid & ~full & ~(byp & m_ready);
  assign pop     = m_ready & ~empty;
  assign m_count = wptr - rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        msg_mem[i]  <= '0;
      end
    end else if (push && !flush) begin
      inst_mem[wptr[AW-1:0]] <= s_inst;
      pc_mem[wptr[AW-1:0]]   <= s_pc;
      msg_mem[wptr[AW-1:0]]  <= s_msg[44:0];
    end
  end

  always_comb begin
    h_inst = inst_mem[rptr[AW-1:0]];
    h_pc   = pc_mem[rptr[AW-1:0]];
    h_msg  = msg_mem[rptr[AW-1:0]];
    if (byp) begin
      h_inst = s_inst;
      h_pc   = s_pc;
      h_msg  = s_msg[44:0];
    end
  end

  assign m_inst         = h_inst;
  assign m_pc           = h_pc;
  assign m_type         = h_msg[8:0];
  assign m_jump_ofs_imm = h_msg[29:9];
  assign m_rs1_vld      = h_msg[32];
  assign m_rs2_vld      = h_msg[31];
  assign m_rd_vld       = h_msg[30];
  assign m_csr_addr     = h_msg[44:33];
  assign m_jump_target  = h_pc +
    {{11{h_msg[29]}}, h_msg[29:9]};

endmodule

// File: tb/tb_panda_risc_v_inst_buf.sv
// Directed bench for panda_risc_v_inst_buf (DEPTH=4).
// Vector table for fill/drain plus sequences for decode, stream, flush, bypass, reset.
module tb_panda_risc_v_inst_buf;

`ifdef PANDA_RISC_V_INST_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic [63:0] s_msg;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [8:0]  m_type;
  logic [20:0] m_jump_ofs_imm;
  logic        m_rs1_vld;
  logic        m_rs2_vld;
  logic        m_rd_vld;
  logic [11:0] m_csr_addr;
  logic [31:0] m_jump_target;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  m_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  panda_risc_v_inst_buf #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_inst(s_inst), .s_pc(s_pc), .s_msg(s_msg),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_inst(m_inst), .m_pc(m_pc), .m_type(m_type),
    .m_jump_ofs_imm(m_jump_ofs_imm),
    .m_rs1_vld(m_rs1_vld), .m_rs2_vld(m_rs2_vld),
    .m_rd_vld(m_rd_vld), .m_csr_addr(m_csr_addr),
    .m_jump_target(m_jump_target),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_count(m_count)
  );

  typedef struct {
    logic        sv;
    logic        mr;
    logic [31:0] inst;
    logic        e_valid;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        ci;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic sv, logic mr,
      logic [31:0] inst, logic ev, logic er,
      logic [2:0] ec, logic ci, logic [31:0] ei);
    vec_t v;
    v.sv = sv; v.mr = mr; v.inst = inst;
    v.e_valid = ev; v.e_ready = er;
    v.e_count = ec; v.ci = ci; v.e_inst = ei;
    return v;
  endfunction

  function automatic logic [63:0] mkmsg(
      logic [8:0] ty, logic [20:0] ofs,
      logic [2:0] flg, logic [11:0] csr);
    return {19'h7FFFF, csr, flg, ofs, ty};
  endfunction

  function automatic logic [31:0] ti(int k);
    return 32'hA000_0000 + k;
  endfunction

  logic [31:0] q[$];
  logic [31:0] nxt;

  initial begin
    tbl[0]  = mk(0, 0, 0,     0, 1, 0, 1, 0);
    tbl[1]  = mk(1, 0, ti(0), BYP, 1, 0, 1,
                 BYP ? ti(0) : 32'h0);
    tbl[2]  = mk(1, 0, ti(1), 1, 1, 1, 1, ti(0));
    tbl[3]  = mk(1, 0, ti(2), 1, 1, 2, 1, ti(0));
    tbl[4]  = mk(1, 0, ti(3), 1, 1, 3, 1, ti(0));
    tbl[5]  = mk(1, 0, ti(4), 1, 0, 4, 1, ti(0));
    tbl[6]  = mk(1, 1, ti(4), 1, 0, 4, 1, ti(0));
    tbl[7]  = mk(1, 0, ti(4), 1, 1, 3, 1, ti(1));
    tbl[8]  = mk(0, 1, 0,     1, 0, 4, 1, ti(1));
    tbl[9]  = mk(0, 1, 0,     1, 1, 3, 1, ti(2));
    tbl[10] = mk(0, 1, 0,     1, 1, 2, 1, ti(3));
    tbl[11] = mk(0, 1, 0,     1, 1, 1, 1, ti(4));
    tbl[12] = mk(0, 0, 0,     0, 1, 0, 0, 0);

    rst_n = 0; flush = 0; s_valid = 0; m_ready = 0;
    s_inst = 0; s_pc = 0; s_msg = 0;
    #2;
    chk("rst_count", m_count, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_tgt", m_jump_target, 0);
    tick();
    rst_n = 1;
    tick();

    // fill to full, hold 5th word, then drain
    for (int i = 0; i < 13; i++) begin
      s_valid = tbl[i].sv;
      m_ready = tbl[i].mr;
      s_inst  = tbl[i].inst;
      s_pc    = 32'h100 + 32'(4 * i);
      s_msg   = 0;
      #2;
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_count", i), m_count, tbl[i].e_count);
      if (tbl[i].ci)
        chk($sformatf("tbl%0d_inst", i), m_inst, tbl[i].e_inst);
      tick();
    end
    s_valid = 0; m_ready = 0;

    // head decode: negative and wrapping offsets
    s_valid = 1; s_inst = 32'h1111;
    s_pc = 32'h0000_1000;
    s_msg = mkmsg(9'h155, 21'h1FFFF8, 3'b100, 12'hABC);
    tick();
    s_inst = 32'h2222; s_pc = 32'hFFFF_FFF0;
    s_msg = mkmsg(9'h0AA, 21'h000020, 3'b011, 12'h123);
    tick();
    s_valid = 0;
    #2;
    chk("dec_tgt0", m_jump_target, 32'h0000_0FF8);
    chk("dec_type0", m_type, 9'h155);
    chk("dec_ofs0", m_jump_ofs_imm, 21'h1FFFF8);
    chk("dec_flg0", {m_rs1_vld, m_rs2_vld, m_rd_vld}, 3'b100);
    chk("dec_csr0", m_csr_addr, 12'hABC);
    m_ready = 1;
    tick();
    chk("dec_tgt1", m_jump_target, 32'h0000_0010);
    chk("dec_type1", m_type, 9'h0AA);
    chk("dec_flg1", {m_rs1_vld, m_rs2_vld, m_rd_vld}, 3'b011);
    chk("dec_pc1", m_pc, 32'hFFFF_FFF0);
    tick();
    m_ready = 0;
    chk("dec_empty", m_valid, 0);

    // steady stream with 2 buffered
    q.delete();
    for (int k = 0; k < 2; k++) begin
      s_valid = 1; s_inst = 32'hB000_0000 + k;
      s_msg = 0; s_pc = 0;
      q.push_back(s_inst);
      tick();
    end
    m_ready = 1;
    for (int k = 2; k < 22; k++) begin
      nxt = 32'hB000_0000 + 32'(k);
      s_inst = nxt;
      #2;
      chk($sformatf("strm%0d_inst", k), m_inst, q[0]);
      chk($sformatf("strm%0d_count", k), m_count, 2);
      tick();
      void'(q.pop_front());
      q.push_back(nxt);
    end
    s_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk($sformatf("strm_drain%0d", k), m_inst, q[0]);
      tick();
      void'(q.pop_front());
    end
    m_ready = 0;
    chk("strm_empty", m_count, 0);

    // flush with concurrent push
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_inst = 32'hC000_0000 + k;
      tick();
    end
    chk("fl_pre_count", m_count, 3);
    s_inst = 32'hDEAD_BEEF; flush = 1;
    tick();
    flush = 0; s_valid = 0;
    chk("fl_valid", m_valid, 0);
    chk("fl_count", m_count, 0);
    m_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("fl_idle%0d", k), m_valid, 0);
      tick();
    end
    m_ready = 0;
    s_valid = 1; s_inst = 32'h5A5A_0001;
    tick();
    s_valid = 0;
    chk("fl_post_inst", m_inst, 32'h5A5A_0001);
    chk("fl_post_count", m_count, 1);
    m_ready = 1;
    tick();
    m_ready = 0;

    // same-cycle bypass vs one-cycle latency
    s_valid = 1; m_ready = 1; s_inst = 32'h7777_0001;
    #2;
    chk("byp_valid", m_valid, BYP);
    if (BYP) chk("byp_inst", m_inst, 32'h7777_0001);
    tick();
    s_valid = 0;
    chk("byp_count", m_count, BYP ? 3'd0 : 3'd1);
    chk("byp_valid_after", m_valid, !BYP);
    if (!BYP) chk("lat_inst", m_inst, 32'h7777_0001);
    tick();
    m_ready = 0;
    chk("byp_drained", m_count, 0);

    // asynchronous reset mid-transfer
    s_valid = 1; s_inst = 32'h9999_0000;
    s_pc = 32'h4000;
    s_msg = mkmsg(9'h1FF, 21'h000100, 3'b111, 12'hFFF);
    tick(); tick();
    s_valid = 0;
    chk("mr_pre_count", m_count, 2);
    rst_n = 0;
    #1;
    chk("mr_count", m_count, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_ready", s_ready, 1);
    chk("mr_inst", m_inst, 0);
    chk("mr_tgt", m_jump_target, 0);
    tick();
    rst_n = 1;
    tick();
    chk("mr_after", m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/panda_risc_v_inst_buf.md
PANDA_RISC_V_INST_BUF -- requirements
Module: panda_risc_v_inst_buf

Interface
REQ-001 SHALL have one parameter: DEPTH, default 4, the number of buffer entries; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  synchronous buffer clear (pipeline flush).
REQ-006 s_inst  input  32  fetched instruction word.
REQ-007 s_pc  input  32  PC of s_inst.
REQ-008 s_msg  input  64  packed pre-decode message, with these fields:
- [8:0]: type flags b,jal,jalr,csr,load,store,mul,div,rem (MSB to LSB).
- [29:9]: jump_ofs_imm.
- [32:30]: rs1_vld, rs2_vld, rd_vld.
- [44:33]: csr_addr.
- [63:45]: ignored.
REQ-009 s_valid / s_ready  input / output  1 / 1  write-side handshake.
REQ-010 m_inst, m_pc  output  32 / 32  head-entry instruction and PC.
REQ-011 m_type  output  9  head-entry type flags, same order as s_msg[8:0].
REQ-012 m_jump_ofs_imm  output  21  head-entry jump offset.
REQ-013 m_rs1_vld, m_rs2_vld, m_rd_vld  output  1 each  head-entry register-use flags.
REQ-014 m_csr_addr  output  12  head-entry CSR address.
REQ-015 m_jump_target  output  32  m_pc + sign-extended m_jump_ofs_imm.
REQ-016 m_valid / m_ready  output / input  1 / 1  read-side handshake.
REQ-017 m_count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL store, per entry, s_inst, s_pc and s_msg[44:0] in a circular FIFO.
REQ-019 SHALL use write and read pointers of width log2(DEPTH)+1 that wrap modulo 2*DEPTH.
REQ-020 SHALL define full as equal low bits with differing MSB, and empty as pointers equal.
REQ-021 SHALL push when s_valid & s_ready.
REQ-022 SHALL pop when m_valid & m_ready.
REQ-023 SHALL drive s_ready = ~full, combinationally from registered state only, with no dependence on m_ready.
REQ-024 SHALL drive m_valid = ~empty, unless REQ-034 applies.
REQ-025 SHALL drive all m_* data outputs combinationally from the entry at the read pointer.
REQ-026 SHALL support push and pop in the same cycle when neither full nor empty: both pointers advance and m_count is unchanged.
REQ-027 SHALL, when full, accept no push even if a pop occurs in the same cycle.
REQ-028 SHALL, when empty, produce no pop.
REQ-029 SHALL leave data presented under m_valid=1 & m_ready=0 stable until popped or flushed.
REQ-030 SHALL compute m_jump_target as sign-extend jump_ofs_imm from 21 to 32 bits, add to m_pc, and discard the carry (mod 2^32); the value is meaningful only for B/JAL.
REQ-031 SHALL, when flush=1, make both pointers 0 and m_count 0 at the next edge; any push or pop in that cycle is discarded.

Reset
REQ-032 SHALL, on rst_n=0, immediately set:
- pointers 0 and m_count 0;
- m_valid 0 and s_ready 1;
- all storage 0, so every m_* data output reads 0 and m_jump_target reads 0.
REQ-033 SHALL treat reset asserted mid-transfer as discarding all buffered entries.

Configuration
REQ-034 With macro PANDA_RISC_V_INST_BUF_BYPASS_EN defined and the buffer empty with s_valid=1 and no flush:
- m_valid=1 in the same cycle;
- all m_* outputs are decoded directly from s_inst/s_pc/s_msg;
- if m_ready=1, nothing is written and the pointers are unchanged;
- otherwise the entry is pushed normally.
REQ-035 Without the macro, minimum push-to-m_valid latency SHALL be 1 cycle and no combinational path SHALL exist from s_* to m_*.

Verification
REQ-036 Reset then DEPTH=4 fill: push 4 entries with m_ready=0 -> s_ready=0 after the 4th push, m_count=4; a 5th s_valid is held and not accepted.
REQ-037 Head decode: push s_pc=0x0000_1000 with jump_ofs_imm=0x1FFFF8 (-8) -> m_jump_target=0x0000_0FF8 and m_type echoes s_msg[8:0].
REQ-038 Steady stream: s_valid=m_ready=1 for 20 cycles with 2 entries buffered -> m_count stays 2, order preserved, pointers wrap with no loss.
REQ-039 Flush: 3 entries buffered, flush=1 together with s_valid=1 -> next cycle m_valid=0, m_count=0, and the flushed-cycle entry is never output.
REQ-040 Bypass: with macro, empty buffer, s_valid=m_ready=1 -> m_inst=s_inst in the same cycle and m_count stays 0; without macro, m_valid first rises 1 cycle after the push.
